// File: rtl/avalon_poll_pkg.sv
// Shared types and constants for the Avalon-MM poll master.
package avalon_poll_pkg;

   localparam int AVM_DATA_W       = 32;
   localparam int POLL_DIV_DEFAULT = 50000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_RWAIT = 3'd2,
      ST_CMP   = 3'd3,
      ST_WRITE = 3'd4
   } poll_state_e;

endpackage

// File: rtl/avalon_poll_master_if.sv
// Avalon-MM bus between the poll master and the interconnect.
interface avalon_poll_master_if #(
   parameter int ADDR_W = 2
);
   import avalon_poll_pkg::*;

   logic [ADDR_W-1:0]     avm_address;
   logic                  avm_read;
   logic                  avm_write;
   logic [AVM_DATA_W-1:0] avm_writedata;
   logic [AVM_DATA_W-1:0] avm_readdata;
   logic                  avm_waitrequest;

   modport master (
      output avm_address, avm_read, avm_write, avm_writedata,
      input  avm_readdata, avm_waitrequest
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_writedata,
      output avm_readdata, avm_waitrequest
   );
endinterface

// File: rtl/avalon_poll_master_tick_gen.sv
// Free-running divider: tick is high for one cycle every POLL_DIV clocks.
module poll_tick_gen
   import avalon_poll_pkg::*;
#(
   parameter int POLL_DIV = POLL_DIV_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);
   localparam int                CNT_W = $clog2(POLL_DIV);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(POLL_DIV - 1);

   logic [CNT_W-1:0] count_r;

   // Wrapping poll counter, independent of FSM state and enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= '0;
      end else if (count_r == LAST) begin
         count_r <= '0;
      end else begin
         count_r <= count_r + CNT_W'(1);
      end
   end

   assign tick = (count_r == LAST);
endmodule

// File: rtl/avalon_poll_master.sv
// Avalon-MM poll master: mirrors a source PIO register into a destination PIO on change.
// Optional POLL_MASTER_DEBOUNCE_EN: a change is only written after two identical polls.
module avalon_poll_master
   import avalon_poll_pkg::*;
#(
   parameter int DATA_W       = 18,
   parameter int ADDR_W       = 2,
   parameter int SRC_ADDR     = 0,
   parameter int DST_ADDR     = 0,
   parameter int POLL_DIV     = POLL_DIV_DEFAULT,
   parameter int READ_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   avalon_poll_master_if.master avm,
   output logic [DATA_W-1:0]    last_value,
   output logic                 busy,
   output logic                 overrun,
   output logic [15:0]          write_count
);
   localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_ADDR);
   localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_ADDR);
   localparam logic [1:0]        LAT_LAST = 2'(READ_LATENCY);
   localparam bit                LAT_ZERO = (READ_LATENCY == 0);

   poll_state_e             state_r, state_nx_s;
   logic                    tick_s, accept_s, diff_s, go_write_s, capture_s;
   logic [DATA_W-1:0]       cap_r, last_r;
   logic                    have_r;
   logic [1:0]              lat_r;
   logic                    read_r, write_r, busy_r, overrun_r;
   logic [ADDR_W-1:0]       addr_r;
   logic [AVM_DATA_W-1:0]   wdata_r;
   logic [15:0]             count_r;
   logic                    unused_rdata_s;

   poll_tick_gen #(.POLL_DIV(POLL_DIV)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick_s)
   );

   assign accept_s       = !avm.avm_waitrequest;
   assign diff_s         = !have_r || (cap_r != last_r);
   assign capture_s      = (state_r == ST_READ && accept_s && LAT_ZERO) ||
                           (state_r == ST_RWAIT && lat_r == LAT_LAST);
   assign unused_rdata_s = ^avm.avm_readdata[AVM_DATA_W-1:DATA_W];

`ifdef POLL_MASTER_DEBOUNCE_EN
   logic [DATA_W-1:0] cand_r;

   // Candidate holds the previous poll's sample; a change must repeat to be written.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cand_r <= '0;
      end else if (state_r == ST_CMP) begin
         cand_r <= cap_r;
      end else begin
         cand_r <= cand_r;
      end
   end

   assign go_write_s = diff_s && (cap_r == cand_r);
`else
   assign go_write_s = diff_s;
`endif

   // Next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE:  if (tick_s && enable) state_nx_s = ST_READ;  else state_nx_s = ST_IDLE;
         ST_READ:  if (!accept_s)        state_nx_s = ST_READ;
                   else if (LAT_ZERO)    state_nx_s = ST_CMP;
                   else                  state_nx_s = ST_RWAIT;
         ST_RWAIT: if (lat_r == LAT_LAST) state_nx_s = ST_CMP;  else state_nx_s = ST_RWAIT;
         ST_CMP:   if (go_write_s)       state_nx_s = ST_WRITE; else state_nx_s = ST_IDLE;
         ST_WRITE: if (accept_s)         state_nx_s = ST_IDLE;  else state_nx_s = ST_WRITE;
         default:                        state_nx_s = ST_IDLE;
      endcase
   end

   // State and bus outputs are registered from the next state so they align with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         busy_r    <= 1'b0;
         read_r    <= 1'b0;
         write_r   <= 1'b0;
         addr_r    <= '0;
         wdata_r   <= '0;
         overrun_r <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         busy_r    <= (state_nx_s != ST_IDLE);
         read_r    <= (state_nx_s == ST_READ);
         write_r   <= (state_nx_s == ST_WRITE);
         overrun_r <= overrun_r || (tick_s && state_r != ST_IDLE);
         case (state_nx_s)
            ST_READ:  addr_r <= SRC_A;
            ST_WRITE: addr_r <= DST_A;
            default:  addr_r <= '0;
         endcase
         if (state_nx_s == ST_WRITE) begin
            wdata_r <= {{(AVM_DATA_W-DATA_W){1'b0}}, cap_r};
         end else begin
            wdata_r <= '0;
         end
      end
   end

   // Read capture, latency count and write bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_r   <= '0;
         lat_r   <= 2'd0;
         last_r  <= '0;
         have_r  <= 1'b0;
         count_r <= 16'd0;
      end else begin
         if (state_r == ST_READ) begin
            lat_r <= 2'd1;
         end else if (state_r == ST_RWAIT) begin
            lat_r <= lat_r + 2'd1;
         end else begin
            lat_r <= lat_r;
         end
         if (capture_s) begin
            cap_r <= avm.avm_readdata[DATA_W-1:0];
         end else begin
            cap_r <= cap_r;
         end
         if (state_r == ST_WRITE && accept_s) begin
            last_r  <= cap_r;
            have_r  <= 1'b1;
            count_r <= count_r + 16'd1;
         end else begin
            last_r  <= last_r;
            have_r  <= have_r;
            count_r <= count_r;
         end
      end
   end

   assign avm.avm_address   = addr_r;
   assign avm.avm_read      = read_r;
   assign avm.avm_write     = write_r;
   assign avm.avm_writedata = wdata_r;
   assign last_value        = last_r;
   assign busy              = busy_r;
   assign overrun           = overrun_r;
   assign write_count       = count_r;
endmodule

// File: tb/tb_avalon_poll_master.sv
// Randomised self-checking bench for avalon_poll_master with a change-detect reference model.
module tb_avalon_poll_master;
   import avalon_poll_pkg::*;

   localparam logic [1:0] SRC_A = 2'd1;
   localparam logic [1:0] DST_A = 2'd2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic        rst_n_a = 1'b0, en_a = 1'b0, wreq_a = 1'b0;
   logic        rst_n_b = 1'b0, en_b = 1'b0, wreq_b = 1'b0;
   logic [31:0] rdata_a = 32'h0;
   logic [17:0] last_a, last_b;
   logic        busy_a, busy_b, ovr_a, ovr_b;
   logic [15:0] wc_a, wc_b;

   avalon_poll_master_if #(.ADDR_W(2)) bus_a ();
   avalon_poll_master_if #(.ADDR_W(2)) bus_b ();

   assign bus_a.avm_readdata    = rdata_a;
   assign bus_a.avm_waitrequest = wreq_a;
   assign bus_b.avm_readdata    = 32'h0000_0077;
   assign bus_b.avm_waitrequest = wreq_b;

   avalon_poll_master #(.DATA_W(18), .ADDR_W(2), .SRC_ADDR(1), .DST_ADDR(2),
                        .POLL_DIV(20), .READ_LATENCY(1)) dut_a (
      .clk(clk), .reset_n(rst_n_a), .enable(en_a), .avm(bus_a),
      .last_value(last_a), .busy(busy_a), .overrun(ovr_a), .write_count(wc_a));

   avalon_poll_master #(.DATA_W(18), .ADDR_W(2), .SRC_ADDR(1), .DST_ADDR(2),
                        .POLL_DIV(3), .READ_LATENCY(1)) dut_b (
      .clk(clk), .reset_n(rst_n_b), .enable(en_b), .avm(bus_b),
      .last_value(last_b), .busy(busy_b), .overrun(ovr_b), .write_count(wc_b));

   // Slave A: programmable stall per transfer, logs accepted transfers and protocol errors.
   int          stall_cfg_a = 0, left_a = 0;
   bit          held_a = 1'b0;
   int          hold_err = 0, both_err = 0, addr_err = 0, rd_stall = 0, wr_stall = 0;
   int          rd_total = 0, wr_total = 0;
   logic [1:0]  s_addr;
   logic        s_rd, s_wr;
   logic [31:0] s_wd;
   int          rd_cyc_q[$];
   int          wr_cyc_q[$];
   logic [31:0] wr_q[$];

   always @(negedge clk) begin
      if (!rst_n_a) begin
         wreq_a = 1'b0; held_a = 1'b0; left_a = 0;
      end else begin
         if (bus_a.avm_read && bus_a.avm_write) both_err++;
         if (held_a && (bus_a.avm_address !== s_addr || bus_a.avm_read !== s_rd ||
                        bus_a.avm_write !== s_wr || bus_a.avm_writedata !== s_wd)) hold_err++;
         if (bus_a.avm_read || bus_a.avm_write) begin
            if (bus_a.avm_read && bus_a.avm_address !== SRC_A) addr_err++;
            if (bus_a.avm_write && bus_a.avm_address !== DST_A) addr_err++;
            if (!held_a) left_a = stall_cfg_a;
            if (left_a > 0) begin
               wreq_a = 1'b1; left_a--; held_a = 1'b1;
               s_addr = bus_a.avm_address; s_rd = bus_a.avm_read;
               s_wr = bus_a.avm_write; s_wd = bus_a.avm_writedata;
               if (bus_a.avm_read) rd_stall++; else wr_stall++;
            end else begin
               wreq_a = 1'b0; held_a = 1'b0;
               if (bus_a.avm_read) begin
                  rd_cyc_q.push_back(cyc); rd_total++;
               end else begin
                  wr_cyc_q.push_back(cyc); wr_q.push_back(bus_a.avm_writedata); wr_total++;
               end
            end
         end else begin
            wreq_a = 1'b0; held_a = 1'b0;
         end
      end
   end

   // Slave B: every transfer stalls for five cycles.
   int left_b = 0;
   bit held_b = 1'b0;
   always @(negedge clk) begin
      if (!rst_n_b) begin
         wreq_b = 1'b0; held_b = 1'b0; left_b = 0;
      end else if (bus_b.avm_read || bus_b.avm_write) begin
         if (!held_b) left_b = 5;
         if (left_b > 0) begin
            wreq_b = 1'b1; left_b--; held_b = 1'b1;
         end else begin
            wreq_b = 1'b0; held_b = 1'b0;
         end
      end else begin
         wreq_b = 1'b0; held_b = 1'b0;
      end
   end

   // Reference model: one sample per poll; a write happens when the sample changes.
   bit          m_have = 1'b0;
   logic [17:0] m_last = 18'h0, m_cand = 18'h0;
   int          m_count = 0;
   logic [31:0] exp_q[$];

   function automatic bit model_poll(input logic [31:0] v);
      logic [17:0] d = v[17:0];
      bit go = !m_have || (d != m_last);
`ifdef POLL_MASTER_DEBOUNCE_EN
      go = go && (d == m_cand);
      m_cand = d;
`endif
      if (go) begin
         m_have = 1'b1; m_last = d; m_count++;
         exp_q.push_back({14'h0, d});
      end
      return go;
   endfunction

   function automatic void model_reset();
      m_have = 1'b0; m_last = 18'h0; m_cand = 18'h0; m_count = 0;
   endfunction

   task automatic do_poll(input logic [31:0] v, input int stall);
      int n0;
      for (int t = 0; t < 400 && busy_a; t++) @(negedge clk);
      rdata_a = v; stall_cfg_a = stall; n0 = rd_total;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk); #1;
         if (rd_total > n0 && !busy_a) break;
      end
      n_checks++;
      if (rd_total != n0 + 1 || busy_a) begin
         n_fail++;
         $display("FAIL poll_complete: reads=%0d busy=%0b, required reads=1 busy=0", rd_total - n0, busy_a);
      end
      void'(model_poll(v));
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({bus_a.avm_read, bus_a.avm_write, busy_a, ovr_a} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: read/write/busy/overrun=%b required 0000",
                  {bus_a.avm_read, bus_a.avm_write, busy_a, ovr_a});
      end
      n_checks++;
      if (bus_a.avm_address !== 2'd0 || bus_a.avm_writedata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_bus: addr=%0h wdata=%08h required 0", bus_a.avm_address, bus_a.avm_writedata);
      end
      n_checks++;
      if (last_a !== 18'h0 || wc_a !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_status: last=%05h count=%0d required 0", last_a, wc_a);
      end
      rst_n_a = 1'b1;
      en_a    = 1'b1;
   endtask

   task automatic test_first_poll();
      int r0 = rd_cyc_q.size();
      int w0 = wr_q.size();
      int e0 = exp_q.size();
      do_poll(32'h0000_0155, 0);
      n_checks++;
      if (wr_q.size() - w0 != exp_q.size() - e0 || wr_q.size() == w0) begin
         n_fail++;
         $display("FAIL first_write_count: writes=%0d required %0d", wr_q.size() - w0, exp_q.size() - e0);
      end else begin
         n_checks++;
         if (wr_q[w0] !== exp_q[e0]) begin
            n_fail++;
            $display("FAIL first_write_data: got %08h required %08h", wr_q[w0], exp_q[e0]);
         end
         // Read accept, RWAIT, CMP, then write accept: two cycles between them.
         n_checks++;
         if (wr_cyc_q[w0] - rd_cyc_q[r0] !== 3) begin
            n_fail++;
            $display("FAIL read_to_write_spacing: got %0d cycles required 3", wr_cyc_q[w0] - rd_cyc_q[r0]);
         end
      end
      n_checks++;
      if (last_a !== m_last || wc_a !== 16'(m_count)) begin
         n_fail++;
         $display("FAIL first_status: last=%05h count=%0d required %05h %0d", last_a, wc_a, m_last, m_count);
      end
   endtask

   task automatic test_same_value();
      int w0 = wr_total;
      int c0 = m_count;
      do_poll(32'hABC0_0155, 0);
      do_poll(32'h1234_0155, 0);
      n_checks++;
      if (wr_total - w0 != m_count - c0 || wc_a !== 16'(m_count)) begin
         n_fail++;
         $display("FAIL same_value: writes=%0d count=%0d required %0d %0d", wr_total - w0, wc_a, m_count - c0, m_count);
      end
   endtask

   task automatic test_waitrequest();
      int h0 = hold_err, b0 = both_err, a0 = addr_err;
      int rs0 = rd_stall, ws0 = wr_stall, w0 = wr_total, c0 = m_count;
      do_poll(32'h0000_02AB, 3);
      do_poll(32'h0000_02AB, 3);
      n_checks++;
      if (hold_err != h0 || both_err != b0 || addr_err != a0) begin
         n_fail++;
         $display("FAIL wait_hold: hold=%0d both=%0d addr=%0d errors required 0",
                  hold_err - h0, both_err - b0, addr_err - a0);
      end
      n_checks++;
      if (rd_stall - rs0 != 6 || wr_stall - ws0 != 3 * (m_count - c0)) begin
         n_fail++;
         $display("FAIL wait_stalls: read=%0d write=%0d required 6 %0d",
                  rd_stall - rs0, wr_stall - ws0, 3 * (m_count - c0));
      end
      n_checks++;
      if (wr_total - w0 != m_count - c0 || last_a !== m_last || ovr_a !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_result: writes=%0d last=%05h overrun=%0b required %0d %05h 0",
                  wr_total - w0, last_a, ovr_a, m_count - c0, m_last);
      end
   endtask

   task automatic test_enable();
      int r0, w0, c0;
      for (int t = 0; t < 400 && busy_a; t++) @(negedge clk);
      r0 = rd_total; w0 = wr_total; c0 = m_count;
      rdata_a = 32'h0000_1111; stall_cfg_a = 1;
      for (int t = 0; t < 100 && !bus_a.avm_read; t++) @(negedge clk);
      en_a = 1'b0;
      repeat (80) @(negedge clk);
      #1;
      void'(model_poll(32'h0000_1111));
      n_checks++;
      if (rd_total - r0 != 1 || wr_total - w0 != m_count - c0 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL enable_drop: reads=%0d writes=%0d busy=%0b required 1 %0d 0",
                  rd_total - r0, wr_total - w0, busy_a, m_count - c0);
      end
      en_a = 1'b1;
   endtask

   task automatic test_random();
      logic [17:0] pool [4] = '{18'h0, 18'h155, 18'h3FFFF, 18'h2AB};
      int w0 = wr_q.size();
      int e0 = exp_q.size();
      int b0 = both_err, h0 = hold_err;
      for (int i = 0; i < 12; i++) begin
         logic [31:0] v;
         v = {14'($urandom), pool[$urandom_range(0, 3)]};
         do_poll(v, int'($urandom_range(0, 3)));
      end
      n_checks++;
      if (wr_q.size() - w0 != exp_q.size() - e0) begin
         n_fail++;
         $display("FAIL random_write_count: got %0d required %0d", wr_q.size() - w0, exp_q.size() - e0);
      end else begin
         for (int i = 0; i < exp_q.size() - e0; i++) begin
            n_checks++;
            if (wr_q[w0 + i] !== exp_q[e0 + i]) begin
               n_fail++;
               $display("FAIL random_write_data[%0d]: got %08h required %08h", i, wr_q[w0 + i], exp_q[e0 + i]);
            end
         end
      end
      n_checks++;
      if (wc_a !== 16'(m_count) || last_a !== m_last || ovr_a !== 1'b0 ||
          both_err != b0 || hold_err != h0) begin
         n_fail++;
         $display("FAIL random_status: count=%0d last=%05h overrun=%0b required %0d %05h 0",
                  wc_a, last_a, ovr_a, m_count, m_last);
      end
   endtask

   task automatic test_reset_mid_write();
      int w0, e0;
      for (int t = 0; t < 400 && busy_a; t++) @(negedge clk);
      rdata_a = {14'h0, ~m_last}; stall_cfg_a = 8;
      for (int t = 0; t < 200 && !bus_a.avm_write; t++) @(negedge clk);
      n_checks++;
      if (bus_a.avm_write !== 1'b1) begin
         n_fail++;
         $display("FAIL midwrite_reach: write=%0b required 1", bus_a.avm_write);
      end
      rst_n_a = 1'b0;
      #1;
      n_checks++;
      if ({bus_a.avm_read, bus_a.avm_write, busy_a, ovr_a} !== 4'b0000 ||
          bus_a.avm_address !== 2'd0 || bus_a.avm_writedata !== 32'h0 ||
          last_a !== 18'h0 || wc_a !== 16'h0) begin
         n_fail++;
         $display("FAIL midwrite_reset: write=%0b wdata=%08h last=%05h count=%0d required all 0",
                  bus_a.avm_write, bus_a.avm_writedata, last_a, wc_a);
      end
      model_reset();
      repeat (2) @(negedge clk);
      rst_n_a = 1'b1;
      w0 = wr_q.size(); e0 = exp_q.size();
      do_poll(32'h0000_0155, 0);
      do_poll(32'h0000_0155, 0);
      n_checks++;
      if (wr_q.size() - w0 != exp_q.size() - e0 || wr_q.size() == w0 || wc_a !== 16'(m_count)) begin
         n_fail++;
         $display("FAIL midwrite_rewrite: writes=%0d count=%0d required %0d %0d",
                  wr_q.size() - w0, wc_a, exp_q.size() - e0, m_count);
      end else begin
         n_checks++;
         if (wr_q[w0] !== exp_q[e0]) begin
            n_fail++;
            $display("FAIL midwrite_rewrite_data: got %08h required %08h", wr_q[w0], exp_q[e0]);
         end
      end
   endtask

   task automatic test_overrun();
      @(negedge clk);
      rst_n_b = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      n_checks++;
      if (ovr_b !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_idle: got %0b required 0", ovr_b);
      end
      en_b = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      n_checks++;
      if (ovr_b !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_set: got %0b required 1", ovr_b);
      end
      en_b = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      n_checks++;
      if (ovr_b !== 1'b1 || busy_b !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_sticky: overrun=%0b busy=%0b required 1 0", ovr_b, busy_b);
      end
      rst_n_b = 1'b0;
      #1;
      n_checks++;
      if (ovr_b !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clear: got %0b required 0", ovr_b);
      end
   endtask

`ifdef POLL_MASTER_DEBOUNCE_EN
   task automatic test_debounce();
      int w0;
      for (int t = 0; t < 400 && busy_a; t++) @(negedge clk);
      rst_n_a = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n_a = 1'b1;
      w0 = wr_q.size();
      do_poll(32'h1, 0);
      do_poll(32'h2, 0);
      do_poll(32'h2, 0);
      n_checks++;
      if (wr_q.size() - w0 != 1) begin
         n_fail++;
         $display("FAIL debounce_count: got %0d required 1", wr_q.size() - w0);
      end else begin
         n_checks++;
         if (wr_q[w0] !== 32'h2) begin
            n_fail++;
            $display("FAIL debounce_data: got %08h required 00000002", wr_q[w0]);
         end
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_poll();
      test_same_value();
      test_waitrequest();
      test_enable();
      test_random();
      test_reset_mid_write();
      test_overrun();
`ifdef POLL_MASTER_DEBOUNCE_EN
      test_debounce();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
